// File: rtl/pipe_perf_monitor_pkg.sv
// Shared definitions for the pipeline performance monitor: FSM encoding and
// readback index width.
package pipe_perf_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } pm_state_e;

    localparam int unsigned RD_IDX_W = 5;

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating up-counter with synchronous clear and a sticky overflow flag that
// sets on the increment that reaches all-ones.
module perf_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == '1) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/pipe_perf_monitor.sv
// Pipeline performance monitor: per-channel event counters plus a cycle
// counter with an optional cycle budget, and a one-cycle-latency readback port.
module pipe_perf_monitor
    import pipe_perf_monitor_pkg::*;
#(
    parameter int unsigned        NUM_EVT   = 4,
    parameter int unsigned        CNT_W     = 32,
    parameter logic [NUM_EVT-1:0] EXCL_MASK = '0
) (
    input  logic                clk_i,
    input  logic                start_i,
    input  logic                en_i,
    input  logic                clr_i,
    input  logic [NUM_EVT-1:0]  evt_i,
    input  logic [CNT_W-1:0]    limit_i,
    input  logic                rd_req_i,
    input  logic [RD_IDX_W-1:0] rd_idx_i,
    output logic                rd_ack_o,
    output logic [CNT_W-1:0]    rd_data_o,
    output logic                rd_err_o,
    output logic                halt_o,
    output logic [CNT_W-1:0]    cycle_o,
    output logic [NUM_EVT-1:0]  ovf_o
);

    logic [CNT_W-1:0]   cnt [NUM_EVT+1];
    logic [NUM_EVT:0]   inc;
    logic [NUM_EVT:0]   ovf;
    logic [NUM_EVT-1:0] evt_ok;
    logic               lower_seen;
    logic               active;
    logic               lim_hit;
    logic [CNT_W-1:0]   cyc_next;

    pm_state_e          state_q;
    logic               halt_q;
    logic               rd_ack_q, rd_err_q, rd_err_d;
    logic [CNT_W-1:0]   rd_data_q, rd_data_d;

    // An exclusive channel is masked by any lower-indexed event in the same cycle.
    always_comb begin
        evt_ok     = '0;
        lower_seen = 1'b0;
        for (int unsigned k = 0; k < NUM_EVT; k++) begin
            evt_ok[k]  = evt_i[k] & ~(EXCL_MASK[k] & lower_seen);
            lower_seen = lower_seen | evt_i[k];
        end
    end

    assign active   = ~clr_i & (((state_q == ST_IDLE) & en_i) | (state_q == ST_RUN));
    assign inc      = {active, {NUM_EVT{active & en_i}} & evt_ok};
    assign cyc_next = ovf[NUM_EVT] ? cnt[NUM_EVT] : cnt[NUM_EVT] + CNT_W'(1);
    assign lim_hit  = (limit_i != '0) && (cyc_next == limit_i);

    for (genvar g = 0; g <= NUM_EVT; g++) begin : g_cnt
        perf_sat_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk_i (clk_i),
            .rst_ni(start_i),
            .clr_i (clr_i),
            .inc_i (inc[g]),
            .cnt_o (cnt[g]),
            .ovf_o (ovf[g])
        );
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_q <= ST_IDLE;
            halt_q  <= 1'b0;
        end else if (clr_i) begin
            state_q <= ST_IDLE;
            halt_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (en_i) begin
                        state_q <= lim_hit ? ST_HALTED : ST_RUN;
                        halt_q  <= lim_hit;
                    end
                end
                ST_RUN: begin
                    if (lim_hit) begin
                        state_q <= ST_HALTED;
                        halt_q  <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    state_q <= ST_HALTED;
                end
                default: begin
                    state_q <= ST_IDLE;
                    halt_q  <= 1'b0;
                end
            endcase
        end
    end

    // Readback samples the registered counters, so data is pre-increment.
    always_comb begin
        rd_data_d = '0;
        rd_err_d  = rd_req_i;
        for (int unsigned i = 0; i <= NUM_EVT; i++) begin
            if (rd_req_i && (rd_idx_i == RD_IDX_W'(i))) begin
                rd_data_d = cnt[i];
                rd_err_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            rd_ack_q  <= rd_req_i;
            rd_data_q <= rd_data_d;
            rd_err_q  <= rd_err_d;
        end
    end

    assign rd_ack_o  = rd_ack_q;
    assign rd_data_o = rd_data_q;
    assign rd_err_o  = rd_err_q;
    assign halt_o    = halt_q;
    assign cycle_o   = cnt[NUM_EVT];
    assign ovf_o     = ovf[NUM_EVT-1:0];

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Self-checking bench for pipe_perf_monitor with two channels, channel 1 exclusive.
module tb_pipe_perf_monitor;

    localparam int unsigned NE = 2;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          start = 1'b0;
    logic          en = 1'b0;
    logic          clr = 1'b0;
    logic [NE-1:0] evt = '0;
    logic [CW-1:0] limit = '0;
    logic          rd_req = 1'b0;
    logic [4:0]    rd_idx = '0;
    logic          rd_ack, rd_err, halt;
    logic [CW-1:0] rd_data, cyc;
    logic [NE-1:0] ovf;

    int errors = 0;
    int checks = 0;

    pipe_perf_monitor #(
        .NUM_EVT  (NE),
        .CNT_W    (CW),
        .EXCL_MASK(2'b10)
    ) dut (
        .clk_i    (clk),
        .start_i  (start),
        .en_i     (en),
        .clr_i    (clr),
        .evt_i    (evt),
        .limit_i  (limit),
        .rd_req_i (rd_req),
        .rd_idx_i (rd_idx),
        .rd_ack_o (rd_ack),
        .rd_data_o(rd_data),
        .rd_err_o (rd_err),
        .halt_o   (halt),
        .cycle_o  (cyc),
        .ovf_o    (ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] data;
        logic          err;
    } rd_exp_t;

    rd_exp_t sb[$];

    // Reference model: 0 idle, 1 run, 2 halted
    int          m_state;
    int unsigned m_cyc;
    int unsigned m_cnt[NE];
    logic [NE-1:0] m_ovf;

    typedef struct {
        logic          en;
        logic          clr;
        logic [1:0]    evt;
        logic          rd;
        logic [4:0]    idx;
        logic [CW-1:0] e_cyc;
        logic          e_halt;
        logic [CW-1:0] e_rd;
        logic          e_err;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_cyc   = 0;
        m_cnt   = '{0, 0};
        m_ovf   = '0;
    endtask

    task automatic model_tick();
        bit act;
        if (clr) begin
            model_reset();
        end else begin
            act = (m_state == 0 && en) || (m_state == 1);
            if (act) begin
                if (en) begin
                    for (int k = 0; k < NE; k++) begin
                        if (evt[k] && !(k == 1 && evt[0]) && m_cnt[k] < 255) begin
                            m_cnt[k]++;
                            if (m_cnt[k] == 255) m_ovf[k] = 1'b1;
                        end
                    end
                end
                if (m_cyc < 255) m_cyc++;
                m_state = (limit != 0 && m_cyc == limit) ? 2 : 1;
            end
        end
    endtask

    task automatic step();
        bit      exp_ack;
        rd_exp_t e;
        exp_ack = rd_req;
        model_tick();
        @(posedge clk);
        #1;
        chk("rd_ack", rd_ack, exp_ack);
        if (exp_ack && sb.size() > 0) begin
            e = sb.pop_front();
            if (rd_ack) begin
                chk("rd_data", rd_data, e.data);
                chk("rd_err", rd_err, e.err);
            end
        end
        chk("cycle_o", cyc, m_cyc);
        chk("halt_o", halt, m_state == 2);
        chk("ovf_o", ovf, m_ovf);
    endtask

    task automatic drive(input logic e, input logic c, input logic [1:0] ev);
        en  = e;
        clr = c;
        evt = ev;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic rd_const(input logic [4:0] idx, input int unsigned d, input logic er);
        rd_exp_t e;
        e.data = d[CW-1:0];
        e.err  = er;
        rd_req = 1'b1;
        rd_idx = idx;
        sb.push_back(e);
        step();
        rd_req = 1'b0;
    endtask

    task automatic rd_model(input logic [4:0] idx);
        rd_exp_t e;
        e.err = 1'b0;
        if (idx < NE) e.data = m_cnt[idx][CW-1:0];
        else if (idx == NE) e.data = m_cyc[CW-1:0];
        else begin
            e.data = '0;
            e.err  = 1'b1;
        end
        rd_req = 1'b1;
        rd_idx = idx;
        sb.push_back(e);
        step();
        rd_req = 1'b0;
    endtask

    initial begin
        model_reset();
        //          en    clr   evt    rd    idx   cyc   halt  rd    err
        tbl[0]  = '{1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 8'd0, 1'b0, 8'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 2'b01, 1'b1, 5'd0, 8'd0, 1'b0, 8'd0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 2'b11, 1'b0, 5'd0, 8'd1, 1'b0, 8'd0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 2'b01, 1'b1, 5'd0, 8'd2, 1'b0, 8'd1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 2'b10, 1'b1, 5'd1, 8'd3, 1'b0, 8'd0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 2'b01, 1'b1, 5'd1, 8'd4, 1'b0, 8'd1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 2'b00, 1'b1, 5'd2, 8'd5, 1'b0, 8'd4, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 2'b00, 1'b1, 5'd0, 8'd6, 1'b0, 8'd2, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 2'b00, 1'b1, 5'd3, 8'd7, 1'b0, 8'd0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 2'b11, 1'b1, 5'd2, 8'd0, 1'b0, 8'd7, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 2'b00, 1'b1, 5'd0, 8'd0, 1'b0, 8'd0, 1'b0};

        // Reset state
        #12;
        chk("rst_cycle", cyc, 0);
        chk("rst_halt", halt, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_ack", rd_ack, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_err", rd_err, 0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven basic counting, exclusivity and readback
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].en, tbl[i].clr, tbl[i].evt);
            if (tbl[i].rd) begin
                rd_exp_t e;
                e.data = tbl[i].e_rd;
                e.err  = tbl[i].e_err;
                sb.push_back(e);
            end
            rd_req = tbl[i].rd;
            rd_idx = tbl[i].idx;
            step();
            chk("tbl_cycle", cyc, tbl[i].e_cyc);
            chk("tbl_halt", halt, tbl[i].e_halt);
        end
        rd_req = 1'b0;

        // Stall/flush exclusivity
        drive(1'b1, 1'b0, 2'b11);
        run(5);
        drive(1'b1, 1'b0, 2'b10);
        run(3);
        drive(1'b0, 1'b0, 2'b00);
        rd_const(5'd0, 5, 1'b0);
        rd_const(5'd1, 3, 1'b0);
        rd_const(5'd2, 10, 1'b0);

        // Back-to-back reads while counting
        drive(1'b1, 1'b0, 2'b01);
        rd_model(5'd0);
        rd_model(5'd1);
        rd_model(5'd2);
        rd_model(5'd31);
        drive(1'b0, 1'b0, 2'b00);
        step();

        // Budget halt
        drive(1'b0, 1'b1, 2'b00);
        step();
        limit = 8'd30;
        drive(1'b1, 1'b0, 2'b01);
        run(29);
        chk("budget_pre_halt", halt, 0);
        chk("budget_pre_cycle", cyc, 29);
        step();
        chk("budget_halt", halt, 1);
        chk("budget_cycle", cyc, 30);
        drive(1'b1, 1'b0, 2'b11);
        run(5);
        chk("budget_frozen", cyc, 30);
        drive(1'b0, 1'b0, 2'b00);
        rd_const(5'd0, 30, 1'b0);
        rd_const(5'd1, 0, 1'b0);

        // Limit lowered below the count, then raised ahead of it
        drive(1'b0, 1'b1, 2'b00);
        limit = 8'd0;
        step();
        drive(1'b1, 1'b0, 2'b00);
        run(10);
        limit = 8'd5;
        run(3);
        chk("lim_low_cycle", cyc, 13);
        chk("lim_low_halt", halt, 0);
        limit = 8'd15;
        run(1);
        chk("lim_up_nohalt", halt, 0);
        run(1);
        chk("lim_up_halt", halt, 1);
        chk("lim_up_cycle", cyc, 15);

        // Clear colliding with an event and the halt condition
        drive(1'b0, 1'b1, 2'b00);
        step();
        limit = 8'd3;
        drive(1'b1, 1'b0, 2'b01);
        run(2);
        drive(1'b1, 1'b1, 2'b11);
        step();
        chk("clr_cycle", cyc, 0);
        chk("clr_halt", halt, 0);
        drive(1'b0, 1'b0, 2'b00);
        step();
        chk("clr_idle", cyc, 0);
        rd_const(5'd0, 0, 1'b0);
        rd_const(5'd1, 0, 1'b0);

        // Saturation
        limit = 8'd0;
        drive(1'b1, 1'b0, 2'b01);
        run(254);
        chk("sat_pre_ovf", ovf, 2'b00);
        step();
        chk("sat_ovf", ovf, 2'b01);
        run(45);
        chk("sat_ovf_hold", ovf, 2'b01);
        chk("sat_cycle", cyc, 255);
        drive(1'b0, 1'b0, 2'b00);
        rd_const(5'd0, 255, 1'b0);
        rd_const(5'd2, 255, 1'b0);
        drive(1'b0, 1'b1, 2'b00);
        step();
        chk("sat_clr_ovf", ovf, 2'b00);

        // Asynchronous reset mid-run with a read outstanding
        drive(1'b1, 1'b0, 2'b01);
        run(5);
        rd_model(5'd0);
        rd_req = 1'b1;
        rd_idx = 5'd0;
        #1;
        start = 1'b0;
        #1;
        chk("arst_ack", rd_ack, 0);
        chk("arst_data", rd_data, 0);
        chk("arst_err", rd_err, 0);
        chk("arst_cycle", cyc, 0);
        chk("arst_halt", halt, 0);
        chk("arst_ovf", ovf, 0);
        rd_req = 1'b0;
        drive(1'b0, 1'b0, 2'b00);
        model_reset();
        #1;
        start = 1'b1;
        run(2);
        chk("arst_no_ack", rd_ack, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_perf_monitor.md
PIPE_PERF_MONITOR -- requirements
Module: pipe_perf_monitor

Interface
REQ-001 SHALL have parameter NUM_EVT, default 4, number of event channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32, width of every counter (8..64).
REQ-003 SHALL have parameter EXCL_MASK, default all-zero, NUM_EVT bits; a set bit k makes channel k exclusive (defined in REQ-014).
REQ-004 SHALL have port clk_i, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port start_i, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port en_i, input, 1, counting enable.
REQ-007 SHALL have port clr_i, input, 1, synchronous clear of all counters and return to IDLE.
REQ-008 SHALL have port evt_i, input, NUM_EVT, per-cycle event strobes (e.g. stall, flush).
REQ-009 SHALL have port limit_i, input, CNT_W, cycle budget; 0 means unlimited.
REQ-010 SHALL have port rd_req_i, input, 1, readback request.
REQ-011 SHALL have port rd_idx_i, input, 5, readback index.
REQ-012 SHALL have ports rd_ack_o (1), rd_data_o (CNT_W), rd_err_o (1), all outputs, readback response.
REQ-013 SHALL have ports halt_o (1), cycle_o (CNT_W) and ovf_o (NUM_EVT), all outputs: budget reached, live cycle count, per-channel saturation flags.

Function
REQ-014 Channel k SHALL count when evt_i[k]=1 and, if EXCL_MASK[k]=1, no lower-indexed channel has evt_i set in that cycle.
REQ-015 SHALL implement FSM states IDLE, RUN and HALTED.
REQ-016 IDLE->RUN SHALL occur on the first cycle with en_i=1; counting starts in that same cycle.
REQ-017 In RUN, cycle_o SHALL increment once per cycle regardless of en_i; event counters SHALL increment only when en_i=1.
REQ-018 RUN->HALTED SHALL occur on the edge at which cycle_o becomes equal to limit_i (limit_i!=0); halt_o SHALL be 1 from the next cycle onward, and cycle_o and the event counters SHALL be frozen in HALTED.
REQ-019 An event coinciding with the halting cycle SHALL be counted.
REQ-020 Counters SHALL saturate at all-ones; ovf_o[k] SHALL set when its counter saturates and stay set until clr_i or reset.
REQ-021 clr_i=1 SHALL zero all counters and ovf_o, deassert halt_o and enter IDLE on the next edge; it has priority over every event, en_i and the halt condition in the same cycle.
REQ-022 A read SHALL return its response exactly one cycle after rd_req_i=1: rd_ack_o pulses high for 1 cycle.
REQ-023 Read index 0..NUM_EVT-1 SHALL return that event counter, index NUM_EVT SHALL return the cycle count, and any other index SHALL return 0 with rd_err_o=1.
REQ-024 Read data SHALL be the counter value sampled at the request edge, before any increment in that cycle.
REQ-025 Back-to-back requests SHALL be accepted every cycle, with no backpressure.
REQ-026 A read SHALL never alter counter state.
REQ-027 Changing limit_i while in RUN SHALL take effect immediately.
REQ-028 If the new limit_i is already below cycle_o, the cycle count SHALL continue upward with no halt (no wrap-compare).

Reset
REQ-029 start_i=0 SHALL asynchronously force: state IDLE, all counters 0, cycle_o=0, ovf_o=0, halt_o=0, rd_ack_o=0, rd_data_o=0, rd_err_o=0.
REQ-030 Reset asserted mid-RUN or mid-read SHALL discard the pending response; no rd_ack_o SHALL follow reset release.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding and the readback index width constant.
REQ-032 Each event channel SHALL be an instance of one sub-module, perf_sat_counter (CNT_W-bit saturating counter with clear, increment and overflow flag), generated NUM_EVT+1 times, the extra instance serving as the cycle counter.

Verification
REQ-033 Directed test, stall/flush exclusivity: NUM_EVT=2, EXCL_MASK=2'b10, evt_i=2'b11 for 5 cycles then 2'b10 for 3 cycles -> ch0=5, ch1=3.
REQ-034 Directed test, budget halt: limit_i=30 with en_i held at 1 -> halt_o rises after cycle 30, cycle_o=30 is frozen, and later events are ignored.
REQ-035 Directed test, saturation: CNT_W=8 with evt_i[0] held for 300 cycles -> counter 255, ovf_o[0]=1.
REQ-036 Directed test, readback: rd_req_i with idx 0,1,NUM_EVT,31 back-to-back -> four consecutive rd_ack_o pulses, correct pre-increment values, rd_err_o only on idx 31.
REQ-037 Directed test, clear collision: clr_i together with an event and the halt condition in the same cycle -> all counters 0, state IDLE, halt_o=0.
REQ-038 Directed test, async reset: start_i pulsed low between clock edges during RUN with a read pending -> all outputs 0 immediately and no rd_ack_o after release.
